key_search_controller: RTL and testbench



---
 rtl/key_search_pkg.sv | 19 +
 rtl/key_search_if.sv | 37 +++
 rtl/key_search_controller.sv | 103 ++++++++++
 tb/tb_key_search_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_search_pkg.sv
// Shared types and default widths for the key search sequencer.
// Provides the FSM state enum and the default key/count widths.
package key_search_pkg;

    localparam int DEF_KEY_WIDTH   = 24;
    localparam int DEF_COUNT_WIDTH = 23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_ADVANCE,
        S_FOUND,
        S_FAILED
    } search_state_t;

endpackage

// File: rtl/key_search_if.sv
// Key generator / decrypt core bundle seen by the search controller.
// master: controller side (increment, core_key, core_start out).
interface key_search_if
    import key_search_pkg::*;
#(
    parameter int KEY_WIDTH = DEF_KEY_WIDTH
) ();

    logic [KEY_WIDTH-1:0] key_in;
    logic                 exhausted_in;
    logic                 increment;
    logic [KEY_WIDTH-1:0] core_key;
    logic                 core_start;
    logic                 core_done;
    logic                 core_valid;

    modport master (
        input  key_in,
        input  exhausted_in,
        output increment,
        output core_key,
        output core_start,
        input  core_done,
        input  core_valid
    );

    modport slave (
        output key_in,
        output exhausted_in,
        input  increment,
        input  core_key,
        input  core_start,
        output core_done,
        output core_valid
    );

endinterface

// File: rtl/key_search_controller.sv
// Sequences candidate keys through the decrypt core until hit/exhaust/timeout.
// Ports: clk, nreset, start, abort, bus (key_search_if.master), status outputs.
module key_search_controller
    import key_search_pkg::*;
#(
    parameter int KEY_WIDTH      = DEF_KEY_WIDTH,
    parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int TIMER_WIDTH    = 17
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   start,
    input  logic                   abort,
    key_search_if.master           bus,
    output logic                   busy,
    output logic                   found,
    output logic                   failed,
    output logic                   timeout,
    output logic [KEY_WIDTH-1:0]   found_key,
    output logic [COUNT_WIDTH-1:0] keys_tried
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_WIDTH-1:0] TO_LAST =
        TIMER_WIDTH'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    search_state_t          state;
    logic [KEY_WIDTH-1:0]   key_q;
    logic                   exh_q;
    logic                   valid_q;
    logic [TIMER_WIDTH-1:0] timer;

    assign busy   = state inside {S_LOAD, S_LAUNCH, S_WAIT,
                                  S_CHECK, S_ADVANCE};
    assign found  = (state == S_FOUND);
    assign failed = (state == S_FAILED);

    // Pulses are state decodes gated by abort so an abort
    // cycle never launches the core or advances the generator.
    assign bus.increment  = (state == S_ADVANCE) && !abort;
    assign bus.core_start = (state == S_LAUNCH) && !abort;
    assign bus.core_key   = key_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= S_IDLE;
            key_q      <= '0;
            exh_q      <= 1'b0;
            valid_q    <= 1'b0;
            timer      <= '0;
            timeout    <= 1'b0;
            found_key  <= '0;
            keys_tried <= '0;
        end else if (abort && busy) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    key_q <= bus.key_in;
                    exh_q <= bus.exhausted_in;
                    state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (bus.core_done) begin
                        valid_q <= bus.core_valid;
                        if (~&keys_tried)
                            keys_tried <= keys_tried + 1'b1;
                        state <= S_CHECK;
                    end else if (TO_EN && timer == TO_LAST) begin
                        timeout <= 1'b1;
                        state   <= S_FAILED;
                    end
                end
                S_CHECK: begin
                    if (valid_q) begin
                        found_key <= key_q;
                        state     <= S_FOUND;
                    end else if (exh_q) begin
                        state <= S_FAILED;
                    end else begin
                        state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    state <= S_LOAD;
                end
                S_FOUND:  state <= S_FOUND;
                S_FAILED: state <= S_FAILED;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_controller.sv
// Scoreboard bench for key_search_controller with generator/core models.
// Stimulus pushes expected launches and terminal status; monitor checks.
module tb_key_search_controller;
    import key_search_pkg::*;

    typedef struct {
        logic        fnd;
        logic        fl;
        logic        to;
        logic [23:0] key;
        logic [22:0] tried;
    } term_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic        abort;
    logic        busy, found, failed, timeout;
    logic [23:0] found_key;
    logic [22:0] keys_tried;

    int checks = 0;
    int errors = 0;
    int inc_cnt = 0;

    logic [23:0] exp_launch[$];
    term_t       exp_term[$];

    always #5 clk = ~clk;

    key_search_if #(.KEY_WIDTH(24)) bus ();

    key_search_controller #(
        .KEY_WIDTH(24),
        .COUNT_WIDTH(23),
        .TIMEOUT_CYCLES(16),
        .TIMER_WIDTH(5)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .start(start),
        .abort(abort),
        .bus(bus),
        .busy(busy),
        .found(found),
        .failed(failed),
        .timeout(timeout),
        .found_key(found_key),
        .keys_tried(keys_tried)
    );

    // Key generator model
    logic [23:0] gen_key;
    logic [23:0] gen_init = 24'h0;
    logic [23:0] key_end = 24'hFFFFFF;
    logic        gen_clr = 1'b0;

    always @(posedge clk or posedge gen_clr) begin
        if (gen_clr) gen_key <= gen_init;
        else if (bus.increment) gen_key <= gen_key + 24'd1;
    end

    assign bus.key_in       = gen_key;
    assign bus.exhausted_in = (gen_key == key_end);

    // Decrypt core model: done 'dly' cycles after start (0 = never)
    logic        cd = 1'b0;
    logic        cv = 1'b0;
    int          dly = 1;
    int          slow_dly = 1;
    logic [23:0] slow_key = 24'hFFFFFF;
    logic [23:0] valid_key = 24'h0;
    bit          valid_en = 1'b0;
    int          cnt = 0;
    bit          pend = 1'b0;
    logic [23:0] ckey = 24'h0;

    always @(negedge clk) begin
        cd = 1'b0;
        cv = 1'b0;
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                cd = 1'b1;
                cv = valid_en && (ckey == valid_key);
                pend = 1'b0;
            end
        end
        if (bus.core_start) begin
            ckey = bus.core_key;
            cnt  = (ckey == slow_key) ? slow_dly : dly;
            pend = (cnt != 0);
        end
    end

    assign bus.core_done  = cd;
    assign bus.core_valid = cv;

    // Monitor / scoreboard
    logic prev_inc = 1'b0, prev_cs = 1'b0, prev_term = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (nreset !== 1'b1) begin
            prev_inc  = 1'b0;
            prev_cs   = 1'b0;
            prev_term = 1'b0;
        end else begin
            if (bus.increment || bus.core_start) begin
                checks++;
                if ((bus.increment && bus.core_start) ||
                    (bus.increment && prev_inc) ||
                    (bus.core_start && prev_cs)) begin
                    errors++;
                    $display("FAIL pulse_rule inc=%0b start=%0b pinc=%0b pstart=%0b",
                             bus.increment, bus.core_start, prev_inc, prev_cs);
                end
            end
            if (bus.increment) inc_cnt++;
            if (bus.core_start) begin
                checks++;
                if (exp_launch.size() == 0) begin
                    errors++;
                    $display("FAIL launch_extra actual=%0h required=none",
                             bus.core_key);
                end else begin
                    logic [23:0] e;
                    e = exp_launch.pop_front();
                    if (bus.core_key !== e) begin
                        errors++;
                        $display("FAIL launch_key actual=%0h required=%0h",
                                 bus.core_key, e);
                    end
                end
            end
            if ((found || failed) && !prev_term) begin
                checks++;
                if (exp_term.size() == 0) begin
                    errors++;
                    $display("FAIL term_extra found=%0b failed=%0b",
                             found, failed);
                end else begin
                    term_t t;
                    t = exp_term.pop_front();
                    if (found !== t.fnd || failed !== t.fl ||
                        timeout !== t.to || keys_tried !== t.tried ||
                        (t.fnd && found_key !== t.key)) begin
                        errors++;
                        $display("FAIL term actual=%0b/%0b/%0b/%0h/%0d required=%0b/%0b/%0b/%0h/%0d",
                                 found, failed, timeout, found_key, keys_tried,
                                 t.fnd, t.fl, t.to, t.key, t.tried);
                    end
                end
            end
            prev_inc  = bus.increment;
            prev_cs   = bus.core_start;
            prev_term = found || failed;
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_inc"}, 64'(bus.increment), 0);
        chk({tag, "_cstart"}, 64'(bus.core_start), 0);
        chk({tag, "_ckey"}, 64'(bus.core_key), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_found"}, 64'(found), 0);
        chk({tag, "_failed"}, 64'(failed), 0);
        chk({tag, "_timeout"}, 64'(timeout), 0);
        chk({tag, "_fkey"}, 64'(found_key), 0);
        chk({tag, "_tried"}, 64'(keys_tried), 0);
    endtask

    task automatic do_reset(logic [23:0] init);
        @(negedge clk);
        nreset  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        gen_init = init;
        gen_clr = 1'b1;
        @(negedge clk);
        gen_clr = 1'b0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        nreset  = 1'b1;
        inc_cnt = 0;
    endtask

    task automatic pulse_start(bit with_abort);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_term(string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (found || failed) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_wait actual=no_terminal required=terminal", name);
    endtask

    task automatic push_term(logic f, logic fl, logic to,
                             logic [23:0] k, logic [22:0] n);
        term_t t;
        t.fnd = f; t.fl = fl; t.to = to; t.key = k; t.tried = n;
        exp_term.push_back(t);
    endtask

    initial begin
        int n;
        bit hit;
        nreset = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;

        // T1: hit on key 3
        do_reset(24'h0);
        key_end = 24'hFFFFFF; valid_en = 1; valid_key = 24'h3; dly = 1;
        for (int k = 0; k <= 3; k++) exp_launch.push_back(24'(k));
        push_term(1, 0, 0, 24'h3, 23'd4);
        pulse_start(0);
        wait_term("t1");
        chk("t1_inc_pulses", 64'(inc_cnt), 3);
        chk("t1_busy", 64'(busy), 0);
        pulse_start(1);
        repeat (3) @(negedge clk);
        #1;
        chk("t1_terminal_hold", 64'(found), 1);
        chk("t1_hold_busy", 64'(busy), 0);

        // T2: exhaustion at key 5
        do_reset(24'h0);
        key_end = 24'h5; valid_en = 0;
        for (int k = 0; k <= 5; k++) exp_launch.push_back(24'(k));
        push_term(0, 1, 0, 24'h0, 23'd6);
        pulse_start(0);
        wait_term("t2");
        chk("t2_inc_pulses", 64'(inc_cnt), 5);
        chk("t2_timeout", 64'(timeout), 0);

        // T3: core never answers
        do_reset(24'h0);
        key_end = 24'hFFFFFF; dly = 0;
        exp_launch.push_back(24'h0);
        push_term(0, 1, 1, 24'h0, 23'd0);
        pulse_start(0);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (bus.core_start) hit = 1;
        end
        chk("t3_saw_start", 64'(hit), 1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (failed) break;
            if (busy) n++;
        end
        chk("t3_wait_cycles", 64'(n), 16);
        chk("t3_timeout", 64'(timeout), 1);

        // T4: done coincides with last timer value
        do_reset(24'h0);
        key_end = 24'h1; dly = 1; slow_key = 24'h0; slow_dly = 16;
        exp_launch.push_back(24'h0);
        exp_launch.push_back(24'h1);
        push_term(0, 1, 0, 24'h0, 23'd2);
        pulse_start(0);
        wait_term("t4");
        chk("t4_inc_pulses", 64'(inc_cnt), 1);
        chk("t4_timeout", 64'(timeout), 0);
        slow_key = 24'hFFFFFF;

        // T5: abort in ADVANCE of key 2, resume, hit on key 7
        do_reset(24'h0);
        key_end = 24'hFFFFFF; valid_en = 1; valid_key = 24'h7; dly = 1;
        for (int k = 0; k <= 2; k++) exp_launch.push_back(24'(k));
        for (int k = 2; k <= 7; k++) exp_launch.push_back(24'(k));
        push_term(1, 0, 0, 24'h7, 23'd9);
        pulse_start(0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (bus.increment && bus.core_key == 24'h2) begin
                abort = 1'b1;
                #1;
                chk("t5_abort_inc", 64'(bus.increment), 0);
                hit = 1;
            end
        end
        chk("t5_reached_adv", 64'(hit), 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("t5_idle", 64'(busy), 0);
        chk("t5_tried", 64'(keys_tried), 3);
        chk("t5_gen_key", 64'(gen_key), 2);
        pulse_start(1);
        wait_term("t5");
        chk("t5_inc_pulses", 64'(inc_cnt), 7);

        // T6: async reset in WAIT, stray done in IDLE, rerun
        do_reset(24'h5);
        valid_en = 1; valid_key = 24'h6; dly = 8;
        exp_launch.push_back(24'h5);
        pulse_start(0);
        repeat (3) @(negedge clk);
        #1;
        chk("t6_busy_wait", 64'(busy), 1);
        @(posedge clk);
        #3;
        nreset = 1'b0;
        #1;
        chk_zero("t6_async");
        @(negedge clk);
        nreset = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("t6_idle_busy", 64'(busy), 0);
        chk("t6_idle_tried", 64'(keys_tried), 0);
        chk("t6_idle_found", 64'(found), 0);
        dly = 1;
        inc_cnt = 0;
        exp_launch.push_back(24'h5);
        exp_launch.push_back(24'h6);
        push_term(1, 0, 0, 24'h6, 23'd2);
        pulse_start(0);
        wait_term("t6");
        chk("t6_inc_pulses", 64'(inc_cnt), 1);

        repeat (2) @(negedge clk);
        chk("launch_queue_empty", 64'(exp_launch.size()), 0);
        chk("term_queue_empty", 64'(exp_term.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
